// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   rx_state_t : receiver FSM states
//   MID_TICK   : oversample tick at the centre of the start bit
//   LAST_TICK  : oversample tick at the centre of a data/parity bit
//                (counted from the centre of the previous bit)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [4:0] MID_TICK  = 5'd7;
  localparam logic [4:0] LAST_TICK = 5'd15;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk  in  destination clock
//   rst  in  synchronous active-high reset; both flops load RST_VAL
//   d    in  asynchronous input
//   q    out synchronized output (2 clk latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= RST_VAL;
      sync_reg <= RST_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 16x-oversampled UART receiver with optional parity,
// framing-error and break detection, and a one-word valid/ready output
// register that reports dropped words as overrun.
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   s_tick      in   one-cycle strobe at 16x baud
//   rx          in   asynchronous serial line, idle high
//   dout        out  received word, LSB = first bit on the line
//   dout_valid  out  dout and the error flags hold an unconsumed word
//   dout_ready  in   consumer accepts the word
//   parity_err  out  parity mismatch for the word in dout
//   frame_err   out  stop bit was low for the word in dout
//   overrun     out  one-cycle pulse: a completed word was dropped
//   break_det   out  one-cycle pulse: break frame seen
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_Tick    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            parity_err,
  output logic            frame_err,
  output logic            overrun,
  output logic            break_det
);

  localparam int             BW        = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [BW-1:0]  LAST_BIT  = BW'(DBIT - 1);
  localparam logic [4:0]     STOP_LAST = 5'(SB_Tick - 1);
  localparam logic           ODD_BIT   = (PARITY_ODD != 0);
  localparam logic           HAS_PAR   = (PARITY_EN != 0);

  // line synchronization and falling-edge detection
  logic rx_sync;
  logic rx_prev_reg;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) rx_prev_reg <= 1'b1;
    else     rx_prev_reg <= rx_sync;
  end

  // receiver FSM
  rx_state_t       state_reg,   state_next;
  logic [4:0]      tick_reg,    tick_next;
  logic [BW-1:0]   bit_reg,     bit_next;
  logic [DBIT-1:0] shift_reg,   shift_next;
  logic            par_bit_reg, par_bit_next;
  logic            par_err_reg, par_err_next;
  logic            stop_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      tick_reg    <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      par_bit_reg <= 1'b0;
      par_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tick_reg    <= tick_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      par_bit_reg <= par_bit_next;
      par_err_reg <= par_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    tick_next    = tick_reg;
    bit_next     = bit_reg;
    shift_next   = shift_reg;
    par_bit_next = par_bit_reg;
    par_err_next = par_err_reg;
    stop_done    = 1'b0;

    case (state_reg)
      IDLE: begin
        // edge rather than level, so a line stuck low cannot restart a frame
        if (rx_prev_reg && !rx_sync) begin
          state_next   = START;
          tick_next    = '0;
          bit_next     = '0;
          par_bit_next = 1'b0;
          par_err_next = 1'b0;
        end
      end

      START: begin
        if (s_tick) begin
          if (tick_reg == MID_TICK) begin
            tick_next  = '0;
            bit_next   = '0;
            // high at mid start bit means the edge was a glitch
            state_next = rx_sync ? IDLE : DATA;
          end else begin
            tick_next = tick_reg + 5'd1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (tick_reg == LAST_TICK) begin
            tick_next  = '0;
            shift_next = {rx_sync, shift_reg[DBIT-1:1]};
            if (bit_reg == LAST_BIT) begin
              bit_next   = '0;
              state_next = HAS_PAR ? PARITY : STOP;
            end else begin
              bit_next = bit_reg + BW'(1);
            end
          end else begin
            tick_next = tick_reg + 5'd1;
          end
        end
      end

      PARITY: begin
        if (s_tick) begin
          if (tick_reg == LAST_TICK) begin
            par_bit_next = rx_sync;
            par_err_next = (^shift_reg) ^ rx_sync ^ ODD_BIT;
            tick_next    = '0;
            bit_next     = '0;
            state_next   = STOP;
          end else begin
            tick_next = tick_reg + 5'd1;
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (tick_reg == STOP_LAST) begin
            stop_done  = 1'b1;
            tick_next  = '0;
            bit_next   = '0;
            state_next = IDLE;
          end else begin
            tick_next = tick_reg + 5'd1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        tick_next  = '0;
        bit_next   = '0;
      end
    endcase
  end

  // frame classification at the stop sample
  logic is_break;
  logic deliver;

  assign is_break = stop_done && !rx_sync && (shift_reg == '0) && !par_bit_reg;
  assign deliver  = stop_done && !is_break;

  // output register
  logic [DBIT-1:0] dout_reg;
  logic            valid_reg;
  logic            perr_reg;
  logic            ferr_reg;
  logic            ovr_reg;
  logic            brk_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_reg  <= '0;
      valid_reg <= 1'b0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
      ovr_reg   <= 1'b0;
      brk_reg   <= 1'b0;
    end else begin
      ovr_reg <= 1'b0;
      brk_reg <= is_break;
      if (deliver) begin
        // a same-cycle consume frees the slot for the new word
        if (!valid_reg || dout_ready) begin
          dout_reg  <= shift_reg;
          perr_reg  <= par_err_reg;
          ferr_reg  <= !rx_sync;
          valid_reg <= 1'b1;
        end else begin
          ovr_reg <= 1'b1;
        end
      end else if (valid_reg && dout_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = valid_reg;
  assign parity_err = perr_reg;
  assign frame_err  = ferr_reg;
  assign overrun    = ovr_reg;
  assign break_det  = brk_reg;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed bench for uart_frame_rx. Two instances share
// clock, tick and reset: u_n is 8N1, u_e is 8E1. Each has its own line.
module tb_uart_frame_rx;

  localparam int TICK_CLK = 16;
  localparam int BIT_CLK  = 16 * TICK_CLK;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_tick;
  logic       rx_n, rx_e;
  logic       ready_n, ready_e;
  logic [7:0] dout_n, dout_e;
  logic       valid_n, valid_e;
  logic       perr_n, perr_e;
  logic       ferr_n, ferr_e;
  logic       ovr_n, ovr_e;
  logic       brk_n, brk_e;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_frame_rx #(.DBIT(8), .SB_Tick(16), .PARITY_EN(0), .PARITY_ODD(0)) u_n (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx_n),
    .dout(dout_n), .dout_valid(valid_n), .dout_ready(ready_n),
    .parity_err(perr_n), .frame_err(ferr_n), .overrun(ovr_n), .break_det(brk_n)
  );

  uart_frame_rx #(.DBIT(8), .SB_Tick(16), .PARITY_EN(1), .PARITY_ODD(0)) u_e (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx_e),
    .dout(dout_e), .dout_valid(valid_e), .dout_ready(ready_e),
    .parity_err(perr_e), .frame_err(ferr_e), .overrun(ovr_e), .break_det(brk_e)
  );

  // transfer monitor, sampled on the falling edge
  int         xfer_n = 0, vcyc_n = 0, ovrc_n = 0, brkc_n = 0;
  int         xfer_e = 0, brkc_e = 0;
  logic [7:0] last_n = '0, last_e = '0;
  logic       lpe_n = 1'b0, lfe_n = 1'b0, lpe_e = 1'b0, lfe_e = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (valid_n) vcyc_n++;
      if (valid_n && ready_n) begin
        xfer_n++; last_n = dout_n; lpe_n = perr_n; lfe_n = ferr_n;
      end
      if (ovr_n) ovrc_n++;
      if (brk_n) brkc_n++;
      if (valid_e && ready_e) begin
        xfer_e++; last_e = dout_e; lpe_e = perr_e; lfe_e = ferr_e;
      end
      if (brk_e) brkc_e++;
    end
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (TICK_CLK - 1) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit on_e, input logic b);
    if (on_e) rx_e = b;
    else      rx_n = b;
    wait_clk(BIT_CLK);
  endtask

  task automatic send_frame(input bit on_e, input logic [7:0] data,
                            input bit with_par, input logic par, input logic stop);
    drive_bit(on_e, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(on_e, data[i]);
    if (with_par) drive_bit(on_e, par);
    drive_bit(on_e, stop);
  endtask

  int x0, v0, o0, b0;

  initial begin
    rst = 1'b1; rx_n = 1'b1; rx_e = 1'b1; ready_n = 1'b1; ready_e = 1'b1;
    wait_clk(4);
    chk("rst dout_n",  32'(dout_n),  32'h0);
    chk("rst valid_n", 32'(valid_n), 32'h0);
    chk("rst perr_n",  32'(perr_n),  32'h0);
    chk("rst ferr_n",  32'(ferr_n),  32'h0);
    chk("rst ovr_n",   32'(ovr_n),   32'h0);
    chk("rst brk_n",   32'(brk_n),   32'h0);
    chk("rst valid_e", 32'(valid_e), 32'h0);
    rst = 1'b0;
    wait_clk(BIT_CLK);

    // 8N1 0xA5
    x0 = xfer_n; v0 = vcyc_n;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wait_clk(32);
    chk("a5 xfers",      32'(xfer_n - x0), 32'd1);
    chk("a5 valid cyc",  32'(vcyc_n - v0), 32'd1);
    chk("a5 dout",       32'(last_n), 32'hA5);
    chk("a5 perr",       32'(lpe_n),  32'h0);
    chk("a5 ferr",       32'(lfe_n),  32'h0);

    // 8E1 0x07: three ones, so even parity needs a 1
    x0 = xfer_e;
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_clk(32);
    chk("07p0 xfers", 32'(xfer_e - x0), 32'd1);
    chk("07p0 dout",  32'(last_e), 32'h07);
    chk("07p0 perr",  32'(lpe_e),  32'h1);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_clk(32);
    chk("07p1 xfers", 32'(xfer_e - x0), 32'd2);
    chk("07p1 perr",  32'(lpe_e),  32'h0);
    chk("07p1 ferr",  32'(lfe_e),  32'h0);

    // 0x3C with low stop bit
    x0 = xfer_n; b0 = brkc_n;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    rx_n = 1'b1;
    wait_clk(BIT_CLK);
    chk("3c xfers", 32'(xfer_n - x0), 32'd1);
    chk("3c dout",  32'(last_n), 32'h3C);
    chk("3c ferr",  32'(lfe_n),  32'h1);
    chk("3c nobrk", 32'(brkc_n - b0), 32'd0);

    // break, then line held low long enough to expose a retrigger
    x0 = xfer_n; b0 = brkc_n; v0 = vcyc_n;
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    wait_clk(12 * BIT_CLK);
    chk("brk pulses", 32'(brkc_n - b0), 32'd1);
    chk("brk xfers",  32'(xfer_n - x0), 32'd0);
    chk("brk vcyc",   32'(vcyc_n - v0), 32'd0);
    rx_n = 1'b1;
    wait_clk(BIT_CLK);

    // overrun: 0x11 held, 0x22 dropped
    ready_n = 1'b0;
    x0 = xfer_n; o0 = ovrc_n;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    wait_clk(32);
    chk("ovr first dout",  32'(dout_n),  32'h11);
    chk("ovr first valid", 32'(valid_n), 32'h1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    wait_clk(32);
    chk("ovr held dout",   32'(dout_n),  32'h11);
    chk("ovr pulses",      32'(ovrc_n - o0), 32'd1);
    ready_n = 1'b1;
    wait_clk(2);
    chk("ovr consume n",   32'(xfer_n - x0), 32'd1);
    chk("ovr consumed",    32'(last_n),  32'h11);
    chk("ovr valid clr",   32'(valid_n), 32'h0);

    // one-tick glitch on idle line
    x0 = xfer_n; b0 = brkc_n; o0 = ovrc_n; v0 = vcyc_n;
    rx_n = 1'b0;
    wait_clk(TICK_CLK);
    rx_n = 1'b1;
    wait_clk(2 * BIT_CLK);
    chk("glitch vcyc", 32'(vcyc_n - v0), 32'd0);
    chk("glitch brk",  32'(brkc_n - b0), 32'd0);
    chk("glitch ovr",  32'(ovrc_n - o0), 32'd0);

    // reset during data bit 4, then a clean 0x5A
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1);
    rx_n = 1'b1;
    wait_clk(BIT_CLK / 2);
    rst = 1'b1;
    wait_clk(1);
    chk("mid rst dout_n",  32'(dout_n),  32'h0);
    chk("mid rst valid_n", 32'(valid_n), 32'h0);
    chk("mid rst ferr_n",  32'(ferr_n),  32'h0);
    chk("mid rst dout_e",  32'(dout_e),  32'h0);
    rst = 1'b0;
    wait_clk(6 * BIT_CLK);
    x0 = xfer_n;
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    wait_clk(32);
    chk("5a xfers", 32'(xfer_n - x0), 32'd1);
    chk("5a dout",  32'(last_n), 32'h5A);
    chk("5a ferr",  32'(lfe_n),  32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Serial-to-parallel UART receiver with optional parity, framing-error and break detection, and a one-word valid/ready output register with overrun reporting. It sits at the line end of the UART link, opposite `uart_tx`. It is driven by the shared `Baud_rate_generator` 16x oversampling tick. Its output register feeds the RX `seq_mem` FIFO or a direct consumer.

## Interface
- `DBIT`, 8, data bits per frame (5..9)
- `SB_Tick`, 16, stop-bit length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- `PARITY_EN`, 0, 1 = a parity bit follows the data bits
- `PARITY_ODD`, 0, 1 = odd parity, 0 = even parity (ignored when `PARITY_EN` = 0)

- `clk`  in  1  clock; single clock domain
- `rst`  in  1  reset; synchronous and active-high
- `s_tick`  in  1  one-cycle strobe at 16x the baud rate
- `rx`  in  1  asynchronous serial line; idle high
- `dout`  out  DBIT  received word, LSB = first bit received
- `dout_valid`  out  1  `dout` and its error flags are valid
- `dout_ready`  in  1  consumer accepts the word
- `parity_err`  out  1  parity mismatch for the word in `dout`
- `frame_err`  out  1  stop bit sampled low for the word in `dout`
- `overrun`  out  1  one-cycle pulse: a completed word was dropped
- `break_det`  out  1  one-cycle pulse: break frame detected

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. A third flop holds the previous synced value for falling-edge detection.
- Tick counter is 5 bits; bit counter is ceil(log2(DBIT)) bits. Both clear on every state entry.
- State `IDLE`: on a synced falling edge (prev = 1, now = 0), go to `START`. A line held low never retriggers.
- State `START`: count `s_tick`. At count 7, if synced `rx` = 0, go to `DATA`; otherwise return to `IDLE` (glitch rejected).
- State `DATA`: at tick count 15, sample `rx` into the shift register MSB and shift right (LSB first). After `DBIT` samples, go to `PARITY` if `PARITY_EN`, else `STOP`.
- State `PARITY`: at count 15, sample the parity bit. Computed error = (XOR of data bits, XOR of parity bit, XOR `PARITY_ODD`) != 0. Go to `STOP`.
- State `STOP`: at count `SB_Tick`-1, sample `rx`; low sets frame error. Return to `IDLE` and deliver the word.
- Break: stop sampled low AND all data bits 0 AND parity bit 0 (or absent). Result: `break_det` pulses, no word is delivered, and `overrun` is not affected.
- Delivery when `dout_valid` = 0, or when `dout_valid` = 1 and `dout_ready` = 1 in the same cycle: load `dout`, `parity_err` and `frame_err`, and set `dout_valid`. No overrun.
- Delivery when `dout_valid` = 1 and `dout_ready` = 0: the new word is discarded, the held word is kept unchanged, and `overrun` pulses.
- Consume: `dout_valid` AND `dout_ready` with no delivery in that cycle clears `dout_valid`. `dout` holds its last value.
- `parity_err` and `frame_err` are 0 when parity is disabled or no error occurred. They change only on a load.

## Timing
- Reset values: `dout` = 0, `dout_valid` = 0, `parity_err` = 0, `frame_err` = 0, `overrun` = 0, `break_det` = 0. FSM state = `IDLE`, both synchronizer flops = 1.
- Reset asserted mid-frame discards the partial frame. Reception resumes only after a fresh falling edge.
- `rx` to FSM latency: 2 `clk` cycles.
- `dout_valid`, `overrun` and `break_det` assert on the `clk` edge after the `s_tick` cycle that completes the stop count. All outputs are registered.
- `s_tick` is required to be at most 1 pulse per `clk`. With no `s_tick`, the FSM holds its state.
- `dout_ready` may be held high permanently; delivery is then one word per frame with no stalls.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state enum: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`
  - `MID_TICK` = 7 and `LAST_TICK` = 15 constants
- Sub-module `sync_2ff` (2-flop synchronizer, reset value parameter). It is reusable for other asynchronous inputs.
- Everything else stays in one module. Target size is about 200 lines.

## Test plan
- 8N1, frame 0xA5 at 16 `clk` per tick, `dout_ready` = 1 -> `dout` = 0xA5, `dout_valid` one cycle, both error flags 0.
- 8E1, frame 0x07 with parity bit 0 -> `dout` = 0x07, `parity_err` = 1. Repeat with parity bit 1 -> `parity_err` = 0.
- 8N1, 0x3C with stop bit low -> `frame_err` = 1. Then all-zero data with stop low -> `break_det` pulse, `dout_valid` stays 0, no retrigger until `rx` returns high.
- `dout_ready` = 0; frames 0x11 then 0x22 -> `dout` stays 0x11 and `overrun` pulses once. Then ready = 1 -> 0x11 is consumed.
- 1-tick-wide low glitch on an idle line -> no state leaves `IDLE` for more than 8 ticks and no output. Also, `rst` asserted during bit 4 -> all outputs read 0 next cycle, and a following 0x5A frame is received correctly.
